// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified memory port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, IF_BUSY, ME_BUSY)
//   owner_t     : bus owner encoding (OWN_IF=0, OWN_ME=1)
package mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 20;
   localparam int unsigned DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      ME_BUSY = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_ME = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant decision for the unified memory port: eligibility masking, ME-first
// priority and the run counter that bounds consecutive ME grants while IF waits.
//   clk, rst_n          : clock, async active-low reset
//   idle                : arbiter FSM is in IDLE (grants only happen there)
//   if_req, if_flush    : IF request and branch flush
//   if_valid, me_valid  : completion pulses currently on the outputs
//   me_req              : ME request
//   grant_c, owner_c    : combinational grant and its owner
module mem_arb_grant
   import mem_arb_pkg::*;
#(
   parameter int unsigned MAX_D_RUN = 4
)
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   idle,
   input  logic   if_req,
   input  logic   if_flush,
   input  logic   if_valid,
   input  logic   me_req,
   input  logic   me_valid,
   output logic   grant_c,
   output owner_t owner_c
);

   localparam int unsigned RUN_W = $clog2(MAX_D_RUN + 1);

   logic [RUN_W-1:0] run_q;
   logic [RUN_W-1:0] run_d;
   logic             if_elig;
   logic             me_elig;

   // A requester completing this cycle sits out, so it cannot be granted twice.
   always_comb begin
      grant_c = 1'b0;
      owner_c = OWN_IF;
      if_elig = if_req & ~if_flush & ~if_valid;
      me_elig = me_req & ~me_valid;
      if (idle) begin
         if (me_elig && (!if_elig || (run_q < RUN_W'(MAX_D_RUN)))) begin
            grant_c = 1'b1;
            owner_c = OWN_ME;
         end else if (if_elig) begin
            grant_c = 1'b1;
            owner_c = OWN_IF;
         end
      end
   end

   // Run counts ME grants made while IF is asking; any IF grant or IF going quiet resets it.
   always_comb begin
      run_d = run_q;
      if (idle) begin
         if (grant_c && (owner_c == OWN_IF)) begin
            run_d = '0;
         end else if (!if_req) begin
            run_d = '0;
         end else if (grant_c && (run_q != RUN_W'(MAX_D_RUN))) begin
            run_d = run_q + RUN_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q <= '0;
      end else begin
         run_q <= run_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and the memory stage
// (ME). One bus transaction at a time over a req/ack handshake; ME has
// priority with a starvation guard for IF.
//   clk, rst_n                      : clock, async active-low reset
//   if_req/if_addr/if_flush         : IF read request, address, branch cancel
//   if_rdata/if_valid               : IF response and completion pulse
//   me_req/me_wr/me_addr/me_wdata   : ME request (read or write)
//   me_rdata/me_valid               : ME response and completion pulse
//   stall_if, stall_me              : combinational pipeline stalls
//   mem_req/mem_wr/mem_addr/mem_wdata : registered bus request
//   mem_rdata, mem_ack              : bus response
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned MAX_D_RUN = 4
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              me_req,
   input  logic              me_wr,
   input  logic [ADDR_W-1:0] me_addr,
   input  logic [DATA_W-1:0] me_wdata,
   output logic [DATA_W-1:0] me_rdata,
   output logic              me_valid,
   output logic              stall_if,
   output logic              stall_me,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   arb_state_t        state_q;
   arb_state_t        state_d;
   logic              drop_q;
   logic              drop_d;
   logic              mem_req_d;
   logic              mem_wr_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_d;
   logic              if_valid_d;
   logic              me_valid_d;
   logic [DATA_W-1:0] if_rdata_d;
   logic [DATA_W-1:0] me_rdata_d;
   logic              idle_c;
   logic              grant_c;
   owner_t            owner_c;
   logic              ack_c;

   assign stall_if = if_req & ~if_valid;
   assign stall_me = me_req & ~me_valid;
   assign idle_c   = (state_q == IDLE);
   // The bus can only complete something it was asked for.
   assign ack_c    = mem_ack & mem_req;

   mem_arb_grant #(
      .MAX_D_RUN (MAX_D_RUN)
   ) u_grant (
      .clk      (clk),
      .rst_n    (rst_n),
      .idle     (idle_c),
      .if_req   (if_req),
      .if_flush (if_flush),
      .if_valid (if_valid),
      .me_req   (me_req),
      .me_valid (me_valid),
      .grant_c  (grant_c),
      .owner_c  (owner_c)
   );

   // Next state, bus request and response capture.
   always_comb begin
      state_d     = state_q;
      drop_d      = drop_q;
      mem_req_d   = mem_req;
      mem_wr_d    = mem_wr;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      if_valid_d  = 1'b0;
      me_valid_d  = 1'b0;
      if_rdata_d  = if_rdata;
      me_rdata_d  = me_rdata;
      case (state_q)
         IDLE: begin
            if (grant_c) begin
               mem_req_d = 1'b1;
               if (owner_c == OWN_ME) begin
                  state_d     = ME_BUSY;
                  mem_wr_d    = me_wr;
                  mem_addr_d  = me_addr;
                  mem_wdata_d = me_wdata;
               end else begin
                  state_d     = IF_BUSY;
                  mem_wr_d    = 1'b0;
                  mem_addr_d  = if_addr;
                  mem_wdata_d = '0;
               end
            end
         end
         IF_BUSY: begin
            // A flushed fetch still runs to completion on the bus; only the pulse is dropped.
            if (ack_c) begin
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               if_rdata_d = mem_rdata;
               if_valid_d = ~(drop_q | if_flush);
               drop_d     = 1'b0;
            end else if (if_flush) begin
               drop_d = 1'b1;
            end
         end
         ME_BUSY: begin
            if (ack_c) begin
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               me_rdata_d = mem_rdata;
               me_valid_d = 1'b1;
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         drop_q    <= 1'b0;
         mem_req   <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_valid  <= 1'b0;
         me_valid  <= 1'b0;
         if_rdata  <= '0;
         me_rdata  <= '0;
      end else begin
         state_q   <= state_d;
         drop_q    <= drop_d;
         mem_req   <= mem_req_d;
         mem_wr    <= mem_wr_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         if_valid  <= if_valid_d;
         me_valid  <= me_valid_d;
         if_rdata  <= if_rdata_d;
         me_rdata  <= me_rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run checked cycle by cycle against a rule-level reference model.
module tb_mem_port_arbiter;

   localparam int unsigned AW   = 20;
   localparam int unsigned DW   = 16;
   localparam int unsigned MAXR = 4;

   logic          clk;
   logic          rst_n;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_flush;
   logic [DW-1:0] if_rdata;
   logic          if_valid;
   logic          me_req;
   logic          me_wr;
   logic [AW-1:0] me_addr;
   logic [DW-1:0] me_wdata;
   logic [DW-1:0] me_rdata;
   logic          me_valid;
   logic          stall_if;
   logic          stall_me;
   logic          mem_req;
   logic          mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;

   int checks   = 0;
   int failures = 0;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_RUN(MAXR)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_rdata(if_rdata), .if_valid(if_valid),
      .me_req(me_req), .me_wr(me_wr), .me_addr(me_addr), .me_wdata(me_wdata),
      .me_rdata(me_rdata), .me_valid(me_valid),
      .stall_if(stall_if), .stall_me(stall_me),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model state: who holds the bus (0 none, 1 IF, 2 ME) and what the outputs should be.
   int            m_owner;
   int            m_run;
   bit            m_drop;
   bit            m_req;
   bit            m_wr;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   bit            m_if_valid;
   bit            m_me_valid;
   logic [DW-1:0] m_if_rdata;
   logic [DW-1:0] m_me_rdata;

   function automatic void model_reset();
      m_owner = 0; m_run = 0; m_drop = 0; m_req = 0; m_wr = 0;
      m_addr = '0; m_wdata = '0; m_if_valid = 0; m_me_valid = 0;
      m_if_rdata = '0; m_me_rdata = '0;
   endfunction

   // One clock edge of the arbitration rules, using the inputs present before the edge.
   function automatic void model_step();
      bit if_el;
      bit me_el;
      bit nxt_if_valid;
      bit nxt_me_valid;
      nxt_if_valid = 0;
      nxt_me_valid = 0;
      if (m_owner == 0) begin
         if_el = if_req && !if_flush && !m_if_valid;
         me_el = me_req && !m_me_valid;
         if (me_el && (!if_el || m_run < int'(MAXR))) begin
            m_owner = 2; m_req = 1; m_wr = me_wr; m_addr = me_addr; m_wdata = me_wdata;
            if (if_req) m_run = (m_run < int'(MAXR)) ? m_run + 1 : int'(MAXR);
            else        m_run = 0;
         end else if (if_el) begin
            m_owner = 1; m_req = 1; m_wr = 0; m_addr = if_addr; m_run = 0;
         end else if (!if_req) begin
            m_run = 0;
         end
      end else if (m_owner == 1) begin
         if (mem_ack) begin
            m_owner = 0; m_req = 0; m_if_rdata = mem_rdata;
            nxt_if_valid = !(m_drop || if_flush);
            m_drop = 0;
         end else if (if_flush) begin
            m_drop = 1;
         end
      end else begin
         if (mem_ack) begin
            m_owner = 0; m_req = 0; m_me_rdata = mem_rdata; nxt_me_valid = 1;
         end
      end
      m_if_valid = nxt_if_valid;
      m_me_valid = nxt_me_valid;
   endfunction

   task automatic drive_idle();
      if_req = 0; if_addr = '0; if_flush = 0;
      me_req = 0; me_wr = 0; me_addr = '0; me_wdata = '0;
      mem_ack = 0; mem_rdata = '0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      drive_idle();
      repeat (2) @(negedge clk);
      checks++;
      if ({mem_req, mem_wr, mem_addr, mem_wdata} !== '0) begin
         failures++;
         $display("FAIL reset_bus got=%0b/%0b/%0h/%0h exp=0", mem_req, mem_wr, mem_addr, mem_wdata);
      end
      checks++;
      if ({if_valid, me_valid, if_rdata, me_rdata, stall_if, stall_me} !== '0) begin
         failures++;
         $display("FAIL reset_resp got=%0b/%0b/%0h/%0h exp=0", if_valid, me_valid, if_rdata, me_rdata);
      end
      rst_n = 1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_if_read();
      if_req = 1; if_addr = 20'h12345;
      #1;
      checks++;
      if (stall_if !== 1'b1 || mem_req !== 1'b0) begin
         failures++; $display("FAIL ifrd_n got stall=%0b req=%0b exp stall=1 req=0", stall_if, mem_req);
      end
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 20'h12345 || stall_if !== 1'b1) begin
         failures++;
         $display("FAIL ifrd_n1 got req=%0b wr=%0b addr=%0h stall=%0b exp 1/0/12345/1", mem_req, mem_wr, mem_addr, stall_if);
      end
      mem_ack = 1; mem_rdata = 16'hA5C3;
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b1 || if_rdata !== 16'hA5C3 || stall_if !== 1'b0 || mem_req !== 1'b0) begin
         failures++;
         $display("FAIL ifrd_n2 got valid=%0b data=%0h stall=%0b req=%0b exp 1/a5c3/0/0", if_valid, if_rdata, stall_if, mem_req);
      end
      mem_ack = 0; if_req = 0; mem_rdata = 16'h0000;
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b0 || mem_req !== 1'b0) begin
         failures++; $display("FAIL ifrd_pulse got valid=%0b req=%0b exp 0/0", if_valid, mem_req);
      end
   endtask

   task automatic test_me_write();
      int pulses;
      pulses = 0;
      me_req = 1; me_wr = 1; me_addr = 20'h000F0; me_wdata = 16'hBEEF;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 20'h000F0 || mem_wdata !== 16'hBEEF
             || me_valid !== 1'b0 || stall_me !== 1'b1) begin
            failures++;
            $display("FAIL mewr_hold%0d got req=%0b wr=%0b addr=%0h wd=%0h v=%0b exp 1/1/f0/beef/0", c, mem_req, mem_wr, mem_addr, mem_wdata, me_valid);
         end
         mem_ack = (c == 2);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (me_valid === 1'b1) pulses++;
         if (c == 0) begin
            mem_ack = 0; me_req = 0; me_wr = 0;
            checks++;
            if (me_valid !== 1'b1 || mem_req !== 1'b0 || stall_me !== 1'b0) begin
               failures++; $display("FAIL mewr_done got valid=%0b req=%0b stall=%0b exp 1/0/0", me_valid, mem_req, stall_me);
            end
         end
      end
      checks++;
      if (pulses != 1) begin
         failures++; $display("FAIL mewr_pulses got=%0d exp=1", pulses);
      end
   endtask

   task automatic test_run_guard();
      bit exp_me [10];
      bit prev_req;
      bit last_vme;
      bit last_vif;
      bit is_me;
      int ng;
      exp_me = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
      prev_req = 0; last_vme = 0; last_vif = 0; ng = 0;
      if_req = 1; if_addr = 20'h11111;
      me_req = 1; me_wr = 0; me_addr = 20'h22222;
      for (int cyc = 0; cyc < 80 && ng < 10; cyc++) begin
         @(negedge clk);
         if (mem_req && !prev_req) begin
            is_me = (mem_addr == 20'h22222);
            checks++;
            if (is_me !== exp_me[ng]) begin
               failures++; $display("FAIL run_order grant%0d got me=%0b exp me=%0b", ng, is_me, exp_me[ng]);
            end
            checks++;
            if ((is_me && last_vme) || (!is_me && last_vif)) begin
               failures++; $display("FAIL double_grant grant%0d me=%0b vme=%0b vif=%0b exp no regrant", ng, is_me, last_vme, last_vif);
            end
            ng++;
         end
         last_vme = me_valid;
         last_vif = if_valid;
         prev_req = mem_req;
         mem_ack = mem_req;
         mem_rdata = DW'($urandom);
         // Masking IF during ME's completion cycle lets ME string grants together.
         if_flush = me_valid;
      end
      checks++;
      if (ng != 10) begin
         failures++; $display("FAIL run_timeout got grants=%0d exp=10", ng);
      end
      if_req = 0; me_req = 0; if_flush = 0;
      @(negedge clk);
      mem_ack = 0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_flush();
      bit seen_valid;
      seen_valid = 0;
      if_req = 1; if_addr = 20'h0AAAA;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 20'h0AAAA) begin
         failures++; $display("FAIL flush_grant got req=%0b addr=%0h exp 1/aaaa", mem_req, mem_addr);
      end
      if_flush = 1; if_addr = 20'h0BBBB;
      @(negedge clk);
      if_flush = 0;
      if (if_valid === 1'b1) seen_valid = 1;
      @(negedge clk);
      mem_ack = 1; mem_rdata = 16'hDEAD;
      if (if_valid === 1'b1) seen_valid = 1;
      @(negedge clk);
      mem_ack = 0;
      checks++;
      if (mem_req !== 1'b0 || if_valid !== 1'b0 || seen_valid) begin
         failures++; $display("FAIL flush_drop got req=%0b valid=%0b early=%0b exp 0/0/0", mem_req, if_valid, seen_valid);
      end
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 20'h0BBBB) begin
         failures++; $display("FAIL flush_refetch got req=%0b wr=%0b addr=%0h exp 1/0/bbbb", mem_req, mem_wr, mem_addr);
      end
      mem_ack = 1; mem_rdata = 16'h4242;
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b1 || if_rdata !== 16'h4242) begin
         failures++; $display("FAIL flush_newdata got valid=%0b data=%0h exp 1/4242", if_valid, if_rdata);
      end
      mem_ack = 0; if_req = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      me_req = 1; me_wr = 0; me_addr = 20'h0ABCD; me_wdata = 16'h0;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 20'h0ABCD) begin
         failures++; $display("FAIL rstmid_busy got req=%0b addr=%0h exp 1/abcd", mem_req, mem_addr);
      end
      #2 rst_n = 0;
      #1;
      checks++;
      if ({mem_req, mem_wr, mem_addr, mem_wdata, if_valid, me_valid, if_rdata, me_rdata} !== '0) begin
         failures++;
         $display("FAIL rstmid_async got req=%0b addr=%0h mev=%0b ifv=%0b exp all 0", mem_req, mem_addr, me_valid, if_valid);
      end
      @(negedge clk);
      checks++;
      if (me_valid !== 1'b0 || mem_req !== 1'b0) begin
         failures++; $display("FAIL rstmid_hold got valid=%0b req=%0b exp 0/0", me_valid, mem_req);
      end
      rst_n = 1;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 20'h0ABCD) begin
         failures++; $display("FAIL rstmid_regrant got req=%0b wr=%0b addr=%0h exp 1/0/abcd", mem_req, mem_wr, mem_addr);
      end
      mem_ack = 1; mem_rdata = 16'h1357;
      @(negedge clk);
      checks++;
      if (me_valid !== 1'b1 || me_rdata !== 16'h1357) begin
         failures++; $display("FAIL rstmid_data got valid=%0b data=%0h exp 1/1357", me_valid, me_rdata);
      end
      mem_ack = 0; me_req = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_stray_ack();
      mem_ack = 1; mem_rdata = 16'hFFFF;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if (mem_req !== 1'b0 || if_valid !== 1'b0 || me_valid !== 1'b0) begin
            failures++; $display("FAIL stray_idle%0d got req=%0b ifv=%0b mev=%0b exp 0/0/0", c, mem_req, if_valid, me_valid);
         end
      end
      mem_ack = 0;
      if_req = 1; if_addr = 20'h0F00D;
      @(negedge clk);
      @(negedge clk);
      mem_ack = 1; mem_rdata = 16'h7E57;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 20'h0F00D || if_valid !== 1'b0) begin
         failures++; $display("FAIL stray_read got req=%0b addr=%0h valid=%0b exp 1/f00d/0", mem_req, mem_addr, if_valid);
      end
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b1 || if_rdata !== 16'h7E57) begin
         failures++; $display("FAIL stray_data got valid=%0b data=%0h exp 1/7e57", if_valid, if_rdata);
      end
      mem_ack = 0; if_req = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_random();
      bit busy_seen;
      int lat;
      int waited;
      busy_seen = 0; lat = 0; waited = 0;
      drive_idle();
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      model_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         checks++;
         if (mem_req !== m_req) begin
            failures++; $display("FAIL rnd_req cyc%0d got=%0b exp=%0b", cyc, mem_req, m_req);
         end
         if (m_req) begin
            checks++;
            if (mem_wr !== m_wr || mem_addr !== m_addr || (m_wr && mem_wdata !== m_wdata)) begin
               failures++;
               $display("FAIL rnd_bus cyc%0d got wr=%0b addr=%0h wd=%0h exp %0b/%0h/%0h", cyc, mem_wr, mem_addr, mem_wdata, m_wr, m_addr, m_wdata);
            end
         end
         checks++;
         if (if_valid !== m_if_valid || (m_if_valid && if_rdata !== m_if_rdata)) begin
            failures++; $display("FAIL rnd_if cyc%0d got v=%0b d=%0h exp %0b/%0h", cyc, if_valid, if_rdata, m_if_valid, m_if_rdata);
         end
         checks++;
         if (me_valid !== m_me_valid || (m_me_valid && me_rdata !== m_me_rdata)) begin
            failures++; $display("FAIL rnd_me cyc%0d got v=%0b d=%0h exp %0b/%0h", cyc, me_valid, me_rdata, m_me_valid, m_me_rdata);
         end
         checks++;
         if (stall_if !== (if_req && !m_if_valid) || stall_me !== (me_req && !m_me_valid)) begin
            failures++; $display("FAIL rnd_stall cyc%0d got %0b/%0b", cyc, stall_if, stall_me);
         end
         // IF requester
         if (if_req && if_valid) begin
            if_req = $urandom_range(0, 1) == 1;
            if_addr = AW'($urandom);
         end else if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req = 1; if_addr = AW'($urandom);
         end
         if_flush = ($urandom_range(0, 9) == 0);
         if (if_flush && if_req) if_addr = AW'($urandom);
         // ME requester
         if (me_req && me_valid) begin
            me_req = $urandom_range(0, 1) == 1;
            me_wr = $urandom_range(0, 1) == 1; me_addr = AW'($urandom); me_wdata = DW'($urandom);
         end else if (!me_req && $urandom_range(0, 2) == 0) begin
            me_req = 1; me_wr = $urandom_range(0, 1) == 1; me_addr = AW'($urandom); me_wdata = DW'($urandom);
         end
         // Memory with variable latency and occasional stray acks
         if (mem_req) begin
            if (!busy_seen) begin
               busy_seen = 1; lat = $urandom_range(0, 3); waited = 0;
            end
            mem_ack = (waited >= lat);
            waited++;
         end else begin
            busy_seen = 0;
            mem_ack = ($urandom_range(0, 3) == 0);
         end
         mem_rdata = DW'($urandom);
         @(posedge clk);
         model_step();
         @(negedge clk);
      end
      drive_idle();
      repeat (3) @(negedge clk);
   endtask

   initial begin
      rst_n = 0;
      drive_idle();
      test_reset();
      test_if_read();
      test_me_write();
      test_run_guard();
      test_flush();
      test_reset_mid();
      test_stray_ack();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
